rom_dl_sequencer: RTL and testbench

//  Sequences the HPS ioctl download stream (index 0 ROM, 1 mod byte, 254 DIP) into

---
 rtl/rom_dl_pkg.sv | 19 +
 rtl/dl_fifo.sv | 53 +++++
 rtl/rom_dl_sequencer.sv | 162 ++++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ioctl download sequencer.
package rom_dl_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [7:0]  IDX_ROM   = 8'd0;
  localparam logic [7:0]  IDX_MOD   = 8'd1;
  localparam logic [7:0]  IDX_DIP   = 8'd254;
  localparam logic [24:0] ROM_LIMIT = 25'h80000;

  // FIFO entry: {addr[18:0], data[7:0]}
  localparam int ENTRY_W = 27;

endpackage

// File: rtl/dl_fifo.sv
// Synchronous FIFO for buffered ROM bytes. The caller only issues legal push/pop,
// so no internal full/empty gating is needed.
module dl_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic [AW:0]      count_nxt
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];

  // Next count is exported so the owner can register flags that line up with count.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_ONE;
    end else if (pop && !push) begin
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rom_dl_sequencer.sv
// Routes the HPS ioctl download stream into a ROM byte FIFO, mod/DIP registers and
// board reset sequencing. Optional feature macro: ROM_CHECKSUM_EN (adds checksum port).
//
// state | meaning
// HOLD  | board held in reset, settle counter running
// RUN   | board released, idle
// LOAD  | ROM download in progress
// DRAIN | download ended, FIFO still emptying
module rom_dl_sequencer
  import rom_dl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int RST_HOLD    = 64,
  parameter int WAIT_MARGIN = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic [2:0]  mem_region,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic [7:0]  mod_id,
  output logic [63:0] dip,
  output logic        core_reset,
  output logic        err_overflow,
  output logic        err_range
`ifdef ROM_CHECKSUM_EN
  ,output logic [15:0] checksum
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RST_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_HOLD);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   WAIT_LVL  = (AW+1)'(FIFO_DEPTH - WAIT_MARGIN);

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_nxt;
  logic [AW:0]        count;
  logic [AW:0]        count_nxt;
  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               rom_start;
  logic               rom_wr;
  logic               push_req;
  logic               push;
  logic               pop;

  assign rom_start  = ioctl_download && (ioctl_index == IDX_ROM);
  assign rom_wr     = rom_start && ioctl_wr;
  assign push_req   = rom_wr && (ioctl_addr < ROM_LIMIT);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_CNT);
  assign pop        = !fifo_empty && mem_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);

  dl_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .wdata     ({ioctl_addr[18:0], ioctl_dout}),
    .rdata     (head),
    .count     (count),
    .count_nxt (count_nxt)
  );

  assign mem_req    = !fifo_empty;
  assign mem_region = head[26:24];
  assign mem_addr   = head[23:8];
  assign mem_data   = head[7:0];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= HOLD;
      cnt   <= HOLD_LOAD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Leaving HOLD as the counter reaches zero gives exactly RST_HOLD held cycles.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    core_reset = 1'b1;
    case (state)
      HOLD: begin
        if (rom_start) begin
          state_nxt = LOAD;
        end else if (cnt <= CNT_ONE) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      RUN: begin
        core_reset = 1'b0;
        if (rom_start) state_nxt = LOAD;
      end
      LOAD: begin
        if (!ioctl_download) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      default: state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ioctl_wait   <= 1'b0;
      mod_id       <= 8'hFF;
      dip          <= '0;
      err_overflow <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      ioctl_wait <= (count_nxt >= WAIT_LVL);
      if (push_req && fifo_full && !pop) err_overflow <= 1'b1;
      if (rom_wr && (ioctl_addr >= ROM_LIMIT)) err_range <= 1'b1;
      if (ioctl_download && ioctl_wr && (ioctl_index == IDX_MOD) && (ioctl_addr == '0))
        mod_id <= ioctl_dout;
      if (ioctl_download && ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == '0))
        dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end

`ifdef ROM_CHECKSUM_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      checksum <= '0;
    end else if ((state_nxt == LOAD) && (state != LOAD)) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + {8'h00, mem_data};
    end
  end
`endif

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Bench for rom_dl_sequencer: directed scenarios with literal expectations plus
// randomized download traffic compared every cycle against a queue-based model.
module tb_rom_dl_sequencer;

  localparam int DEPTH  = 8;
  localparam int HOLD   = 64;
  localparam int MARGIN = 2;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_ready = 1'b0;
  logic [2:0]  mem_region;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  mod_id;
  logic [63:0] dip;
  logic        core_reset;
  logic        err_overflow;
  logic        err_range;
`ifdef ROM_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk_sys = ~clk_sys;

  rom_dl_sequencer dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .mem_region     (mem_region),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mod_id         (mod_id),
    .dip            (dip),
    .core_reset     (core_reset),
    .err_overflow   (err_overflow),
    .err_range      (err_range)
`ifdef ROM_CHECKSUM_EN
    ,.checksum      (checksum)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO contents as a queue, board reset as loading/draining
  // flags plus the number of settle cycles still owed.
  logic [26:0] q[$];
  int          hold_left = HOLD;
  bit          loading = 0;
  bit          draining = 0;
  logic [7:0]  m_mod = 8'hFF;
  logic [63:0] m_dip = '0;
  bit          m_ovf = 0;
  bit          m_rng = 0;
  logic [15:0] m_sum = '0;
  int          m_size;
  bit          m_pop;
  bit          chk_en = 0;

  always @(posedge clk_sys) begin
    if (reset) begin
      q.delete();
      hold_left = HOLD;
      loading = 0;
      draining = 0;
      m_mod = 8'hFF;
      m_dip = '0;
      m_ovf = 0;
      m_rng = 0;
      m_sum = '0;
    end else begin
      m_size = q.size();
      m_pop = (m_size > 0) && mem_ready;
      if (loading) begin
        if (!ioctl_download) begin
          loading = 0;
          draining = 1;
        end
      end else if (draining) begin
        if (m_size == 0) begin
          draining = 0;
          hold_left = HOLD;
        end
      end else if (ioctl_download && ioctl_index == 8'd0) begin
        loading = 1;
        hold_left = 0;
        m_sum = '0;
      end else if (hold_left > 0) begin
        hold_left--;
      end
      if (m_pop) begin
        m_sum = m_sum + {8'h00, q[0][7:0]};
        void'(q.pop_front());
      end
      if (ioctl_download && ioctl_wr) begin
        if (ioctl_index == 8'd0) begin
          if (ioctl_addr >= 25'h80000) m_rng = 1;
          else if (m_size < DEPTH || m_pop) q.push_back({ioctl_addr[18:0], ioctl_dout});
          else m_ovf = 1;
        end else if (ioctl_index == 8'd1) begin
          if (ioctl_addr == 0) m_mod = ioctl_dout;
        end else if (ioctl_index == 8'd254) begin
          if (ioctl_addr < 8) m_dip[int'(ioctl_addr[2:0])*8 +: 8] = ioctl_dout;
        end
      end
    end
  end

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("core_reset", core_reset, loading || draining || hold_left > 0);
      check("mem_req", mem_req, q.size() > 0);
      if (q.size() > 0) begin
        check("mem_region", mem_region, q[0][26:24]);
        check("mem_addr", mem_addr, q[0][23:8]);
        check("mem_data", mem_data, q[0][7:0]);
      end
      check("ioctl_wait", ioctl_wait, (DEPTH - q.size()) <= MARGIN);
      check("mod_id", mod_id, m_mod);
      check("dip", dip, m_dip);
      check("err_overflow", err_overflow, m_ovf);
      check("err_range", err_range, m_rng);
`ifdef ROM_CHECKSUM_EN
      check("checksum", checksum, m_sum);
`endif
    end
  end

  task automatic wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    @(negedge clk_sys);
    ioctl_wr    = 1'b0;
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (core_reset && n < 300) begin
      n++;
      @(negedge clk_sys);
    end
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (core_reset && n < 300) begin
      n++;
      @(negedge clk_sys);
    end
    check("run_reached", core_reset, 1'b0);
  endtask

  int          n_hi;
  int          k;
  int          len;
  int          r;
  logic [31:0] rnd;

  initial begin
    repeat (3) @(negedge clk_sys);
    chk_en = 1;
    reset = 1'b0;

    // Power-up settle
    count_high(n_hi);
    check("powerup_hold_cycles", n_hi, 64);
    check("powerup_mod_id", mod_id, 8'hFF);

    // Single ROM byte
    ioctl_download = 1'b1;
    ioctl_index = 8'd0;
    mem_ready = 1'b1;
    wr(8'd0, 25'h10005, 8'hAA);
    check("single_req", mem_req, 1'b1);
    check("single_region", mem_region, 3'd1);
    check("single_addr", mem_addr, 16'h0005);
    check("single_data", mem_data, 8'hAA);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("single_drained", mem_req, 1'b0);
    check("single_drain_reset", core_reset, 1'b1);
    @(negedge clk_sys);
    count_high(n_hi);
    check("post_drain_hold_cycles", n_hi, 64);

    // Backpressure and overflow
    ioctl_download = 1'b1;
    ioctl_index = 8'd0;
    mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr(8'd0, 25'h20000 + 25'(i), 8'hA0 + 8'(i));
      if (i == 4) check("wait_after_5", ioctl_wait, 1'b0);
      if (i == 5) check("wait_after_6", ioctl_wait, 1'b1);
      if (i == 7) check("no_ovf_after_8", err_overflow, 1'b0);
    end
    check("ovf_after_9", err_overflow, 1'b1);
    mem_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_req) begin
        check("drain_order_data", mem_data, 8'hA0 + 8'(k));
        check("drain_order_addr", mem_addr, 16'(k));
        k++;
      end
      @(negedge clk_sys);
    end
    check("drain_count", k, 8);
    ioctl_download = 1'b0;
    wait_run();

    // Out-of-range ROM, mod byte, DIP bytes
    ioctl_download = 1'b1;
    ioctl_index = 8'd0;
    wr(8'd0, 25'h80000, 8'h55);
    check("range_no_req", mem_req, 1'b0);
    check("range_err", err_range, 1'b1);
    wr(8'd1, 25'h0, 8'h03);
    check("mod_id_set", mod_id, 8'h03);
    wr(8'd1, 25'h5, 8'h77);
    check("mod_id_other_addr", mod_id, 8'h03);
    for (int i = 0; i < 8; i++) wr(8'd254, 25'(i), 8'h11 * 8'(i + 1));
    wr(8'd254, 25'd8, 8'h99);
    check("dip_value", dip, 64'h8877665544332211);
    ioctl_download = 1'b0;
    wait_run();

    // Reset in the middle of a load with bytes buffered
    ioctl_download = 1'b1;
    ioctl_index = 8'd0;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'd0, 25'h30000 + 25'(i), 8'(i));
    check("midload_req", mem_req, 1'b1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("midload_flushed", mem_req, 1'b0);
    check("midload_core_reset", core_reset, 1'b1);
    check("midload_err_cleared", err_overflow, 1'b0);
    reset = 1'b0;
    count_high(n_hi);
    check("midload_hold_cycles", n_hi, 64);

    // Random traffic
    for (int s = 0; s < 14; s++) begin
      ioctl_download = 1'b1;
      ioctl_index = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
      len = $urandom_range(20, 100);
      for (int c = 0; c < len; c++) begin
        mem_ready = ($urandom_range(0, 9) < 6);
        if ($urandom_range(0, 1) == 1 && !(ioctl_wait && $urandom_range(0, 3) != 0)) begin
          r = $urandom_range(0, 9);
          rnd = $urandom();
          if (r < 7) begin
            ioctl_index = 8'd0;
            ioctl_addr = ($urandom_range(0, 9) == 0) ? (rnd[24:0] | 25'h80000) : {6'b0, rnd[18:0]};
          end else if (r == 7) begin
            ioctl_index = 8'd1;
            ioctl_addr = 25'($urandom_range(0, 1));
          end else if (r == 8) begin
            ioctl_index = 8'd254;
            ioctl_addr = 25'($urandom_range(0, 11));
          end else begin
            ioctl_index = 8'd7;
            ioctl_addr = {6'b0, rnd[18:0]};
          end
          ioctl_dout = rnd[31:24];
          ioctl_wr = 1'b1;
        end else begin
          ioctl_wr = 1'b0;
        end
        @(negedge clk_sys);
      end
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      len = $urandom_range(5, 120);
      for (int c = 0; c < len; c++) begin
        mem_ready = ($urandom_range(0, 9) < 6);
        @(negedge clk_sys);
      end
    end
    mem_ready = 1'b1;
    wait_run();

`ifdef ROM_CHECKSUM_EN
    ioctl_download = 1'b1;
    ioctl_index = 8'd0;
    wr(8'd0, 25'h0, 8'h01);
    wr(8'd0, 25'h1, 8'hFF);
    wr(8'd0, 25'h2, 8'h10);
    ioctl_download = 1'b0;
    wait_run();
    check("checksum_literal", checksum, 16'h0110);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
